difftest_irp_event_sched: RTL and testbench

//  Per-hart change detector and shared-port scheduler for non-register interrupt-pending difftest events.

---
 rtl/difftest_irp_event_sched.sv | 167 ++++++++++++++++
 tb/tb_difftest_irp_event_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/difftest_irp_event_sched.sv
// rtl/difftest_irp_event_sched.sv - per-hart interrupt-pending change detector and round-robin event port
// Optional feature macro: DIFFTEST_IRP_DROP_CNT_EN (per-hart coalesced-overwrite counters on io_dropCnt).
module difftest_irp_event_sched #(
  parameter int NUM_CORES    = 2,
  parameter int CORE_ID_BASE = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    io_in_valid,
  input  logic [NUM_CORES*10-1:0] io_in_irp,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [9:0]              io_out_irp,
  output logic [7:0]              io_out_coreid
`ifdef DIFFTEST_IRP_DROP_CNT_EN
  ,
  output logic [NUM_CORES*16-1:0] io_dropCnt
`endif
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [7:0] BASE8 = 8'(CORE_ID_BASE);

  logic [9:0]           last_rep_q [NUM_CORES];
  logic [9:0]           last_rep_d [NUM_CORES];
  logic [9:0]           pend_q     [NUM_CORES];
  logic [9:0]           pend_d     [NUM_CORES];
  logic [NUM_CORES-1:0] dirty_q, dirty_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [9:0]           out_irp_q, out_irp_d;
  logic [7:0]           out_coreid_q, out_coreid_d;

  logic                 grant_en;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic [9:0]           shadow  [NUM_CORES];
  logic [NUM_CORES-1:0] granted;
  logic [NUM_CORES-1:0] changed;

  // Round-robin pick: first dirty hart after the last granted one; frozen while the output stalls
  always_comb begin
    grant_en  = !out_valid_q || io_out_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_CORES);
      if (grant_en && !grant_any && dirty_q[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Per-hart view of the newest known value, grant decode and change detection
  always_comb begin
    granted = '0;
    changed = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      shadow[i]  = dirty_q[i] ? pend_q[i] : last_rep_q[i];
      granted[i] = grant_any && (grant_idx == PTR_W'(i));
      changed[i] = io_in_valid[i] && (io_in_irp[10*i +: 10] != shadow[i]);
    end
  end

  // Next state: output stage load and per-hart coalescing of samples
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = out_valid_q;
    out_irp_d    = out_irp_q;
    out_coreid_d = out_coreid_q;
    dirty_d      = dirty_q;
    if (grant_en) begin
      if (grant_any) begin
        out_valid_d  = 1'b1;
        out_irp_d    = pend_q[grant_idx];
        out_coreid_d = BASE8 + 8'(grant_idx);
        rr_ptr_d     = grant_idx;
      end else begin
        out_valid_d  = 1'b0;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      last_rep_d[i] = last_rep_q[i];
      pend_d[i]     = pend_q[i];
      if (granted[i]) begin
        // The granted value becomes the reference; a differing same-cycle sample re-arms the hart
        last_rep_d[i] = pend_q[i];
        if (changed[i]) begin
          pend_d[i]  = io_in_irp[10*i +: 10];
          dirty_d[i] = 1'b1;
        end else begin
          dirty_d[i] = 1'b0;
        end
      end else if (changed[i]) begin
        pend_d[i]  = io_in_irp[10*i +: 10];
        dirty_d[i] = (io_in_irp[10*i +: 10] != last_rep_q[i]);
      end
    end
  end

  // State registers with synchronous active-high reset; hart 0 wins the first grant
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        last_rep_q[i] <= '0;
        pend_q[i]     <= '0;
      end
      dirty_q      <= '0;
      rr_ptr_q     <= PTR_W'(NUM_CORES - 1);
      out_valid_q  <= 1'b0;
      out_irp_q    <= '0;
      out_coreid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        last_rep_q[i] <= last_rep_d[i];
        pend_q[i]     <= pend_d[i];
      end
      dirty_q      <= dirty_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_irp_q    <= out_irp_d;
      out_coreid_q <= out_coreid_d;
    end
  end

  assign io_out_valid  = out_valid_q;
  assign io_out_irp    = out_irp_q;
  assign io_out_coreid = out_coreid_q;

`ifdef DIFFTEST_IRP_DROP_CNT_EN
  logic [15:0] drop_q [NUM_CORES];
  logic [15:0] drop_d [NUM_CORES];

  // Count samples that overwrite a still-unreported value (cancellation included), saturating
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      drop_d[i] = drop_q[i];
      if (changed[i] && dirty_q[i] && !granted[i] && (drop_q[i] != 16'hFFFF)) begin
        drop_d[i] = drop_q[i] + 16'd1;
      end
    end
  end

  // Drop counter registers
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (reset) begin
        drop_q[i] <= '0;
      end else begin
        drop_q[i] <= drop_d[i];
      end
    end
  end

  // Pack counters onto the flat output port
  always_comb begin
    io_dropCnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      io_dropCnt[16*i +: 16] = drop_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_difftest_irp_event_sched.sv
// tb/tb_difftest_irp_event_sched.sv - directed self-checking bench for difftest_irp_event_sched
module tb_difftest_irp_event_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  io_in_valid;
  logic [19:0] io_in_irp;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [9:0]  io_out_irp;
  logic [7:0]  io_out_coreid;
`ifdef DIFFTEST_IRP_DROP_CNT_EN
  logic [31:0] io_dropCnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] ev_q [$];

  // Expected transfers {coreid, irp} when both harts change every cycle
  localparam logic [17:0] EXP4 [9] = '{
    {8'd0, 10'h100}, {8'd1, 10'h201}, {8'd0, 10'h102}, {8'd1, 10'h203},
    {8'd0, 10'h104}, {8'd1, 10'h205}, {8'd0, 10'h106}, {8'd1, 10'h207},
    {8'd0, 10'h107}
  };

  always #5 clock = ~clock;

  difftest_irp_event_sched #(
    .NUM_CORES    (2),
    .CORE_ID_BASE (0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_in_valid   (io_in_valid),
    .io_in_irp     (io_in_irp),
    .io_out_valid  (io_out_valid),
    .io_out_ready  (io_out_ready),
    .io_out_irp    (io_out_irp),
    .io_out_coreid (io_out_coreid)
`ifdef DIFFTEST_IRP_DROP_CNT_EN
    ,
    .io_dropCnt    (io_dropCnt)
`endif
  );

  // Record every accepted event; the handshake is stable mid-cycle
  always @(negedge clock) begin
    if (!reset && io_out_valid && io_out_ready) ev_q.push_back({io_out_coreid, io_out_irp});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [9:0] h0, input logic [9:0] h1);
    io_in_valid = v;
    io_in_irp   = {h1, h0};
  endtask

  function automatic logic [17:0] ev(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 18'h3FFFF;
  endfunction

  function automatic logic [31:0] out_word();
    return 32'({io_out_valid, io_out_coreid, io_out_irp});
  endfunction

  initial begin
    reset        = 1'b1;
    io_out_ready = 1'b0;
    drive(2'b00, 10'h0, 10'h0);
    tick(2);
    reset = 1'b0;
    check("reset_valid",  32'(io_out_valid),  32'd0);
    check("reset_irp",    32'(io_out_irp),    32'd0);
    check("reset_coreid", 32'(io_out_coreid), 32'd0);

    // 1: single change on hart 0 yields exactly one event
    io_out_ready = 1'b1;
    drive(2'b01, 10'h001, 10'h0);
    tick(1);
    drive(2'b00, 10'h0, 10'h0);
    tick(5);
    check("t1_count", 32'(ev_q.size()), 32'd1);
    check("t1_event", 32'(ev(0)), 32'({8'd0, 10'h001}));

    // 2: hart 1 coalesces 002/006/004 behind a stalled hart-0 event
    ev_q.delete();
    io_out_ready = 1'b0;
    drive(2'b01, 10'h005, 10'h0);
    tick(1);
    drive(2'b10, 10'h0, 10'h002);
    tick(1);
    drive(2'b10, 10'h0, 10'h006);
    tick(1);
    drive(2'b10, 10'h0, 10'h004);
    tick(1);
    check("t2_hold", out_word(), 32'({1'b1, 8'd0, 10'h005}));
`ifdef DIFFTEST_IRP_DROP_CNT_EN
    check("t2_drop1", 32'(io_dropCnt[31:16]), 32'd2);
`endif
    io_out_ready = 1'b1;
    drive(2'b00, 10'h0, 10'h0);
    tick(5);
    check("t2_count", 32'(ev_q.size()), 32'd2);
    check("t2_ev0",   32'(ev(0)), 32'({8'd0, 10'h005}));
    check("t2_ev1",   32'(ev(1)), 32'({8'd1, 10'h004}));

    // 3: hart 0 changes then reverts before its grant -> no hart-0 event
    ev_q.delete();
    io_out_ready = 1'b0;
    drive(2'b10, 10'h0, 10'h001);
    tick(1);
    drive(2'b01, 10'h001, 10'h0);
    tick(1);
    drive(2'b01, 10'h005, 10'h0);
    tick(1);
    drive(2'b00, 10'h0, 10'h0);
    io_out_ready = 1'b1;
    tick(5);
    check("t3_count", 32'(ev_q.size()), 32'd1);
    check("t3_ev0",   32'(ev(0)), 32'({8'd1, 10'h001}));
`ifdef DIFFTEST_IRP_DROP_CNT_EN
    check("t3_drop0", 32'(io_dropCnt[15:0]),  32'd1);
    check("t3_drop1", 32'(io_dropCnt[31:16]), 32'd2);
`endif

    // 4: both harts change every cycle -> strict alternation starting at hart 0
    ev_q.delete();
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, 10'(256 + k), 10'(512 + k));
      tick(1);
    end
    drive(2'b00, 10'h0, 10'h0);
    tick(5);
    check("t4_count", 32'(ev_q.size()), 32'd9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t4_ev%0d", k), 32'(ev(k)), 32'(EXP4[k]));
    end

    // 5: five stalled cycles hold the output; sampling keeps coalescing meanwhile
    ev_q.delete();
    io_out_ready = 1'b0;
    drive(2'b11, 10'h3AA, 10'h055);
    tick(1);
    drive(2'b00, 10'h0, 10'h0);
    tick(1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t5_hold%0d", c), out_word(), 32'({1'b1, 8'd1, 10'h055}));
      if (c == 1) drive(2'b01, 10'h3AB, 10'h0);
      else        drive(2'b00, 10'h0, 10'h0);
      tick(1);
    end
    io_out_ready = 1'b1;
    drive(2'b00, 10'h0, 10'h0);
    tick(5);
    check("t5_count", 32'(ev_q.size()), 32'd2);
    check("t5_ev0",   32'(ev(0)), 32'({8'd1, 10'h055}));
    check("t5_ev1",   32'(ev(1)), 32'({8'd0, 10'h3AB}));
`ifdef DIFFTEST_IRP_DROP_CNT_EN
    check("t5_drop0", 32'(io_dropCnt[15:0]),  32'd5);
    check("t5_drop1", 32'(io_dropCnt[31:16]), 32'd6);
`endif

    // 6: reset with an event in flight and dirty harts discards everything
    ev_q.delete();
    io_out_ready = 1'b0;
    drive(2'b11, 10'h011, 10'h022);
    tick(1);
    drive(2'b00, 10'h0, 10'h0);
    tick(1);
    drive(2'b10, 10'h0, 10'h033);
    tick(1);
    check("t6_pre", out_word(), 32'({1'b1, 8'd1, 10'h022}));
    reset = 1'b1;
    drive(2'b00, 10'h0, 10'h0);
    tick(1);
    check("t6_reset", out_word(), 32'd0);
    reset        = 1'b0;
    io_out_ready = 1'b1;
    tick(5);
    check("t6_stale", 32'(ev_q.size()), 32'd0);
`ifdef DIFFTEST_IRP_DROP_CNT_EN
    check("t6_drop", io_dropCnt, 32'd0);
`endif
    ev_q.delete();
    drive(2'b01, 10'h3FF, 10'h0);
    tick(1);
    drive(2'b00, 10'h0, 10'h0);
    tick(5);
    check("t6_count", 32'(ev_q.size()), 32'd1);
    check("t6_ev0",   32'(ev(0)), 32'({8'd0, 10'h3FF}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
